// File: rtl/keycode_lane_events.sv
// rtl/keycode_lane_events.sv - keycode-to-lane press/release event generator
// Turns the level HID keycode into lane events, queued in a FWFT FIFO.
module keycode_lane_events #(
  parameter logic [7:0] LANE0_CODE = 8'h07,
  parameter logic [7:0] LANE1_CODE = 8'h09,
  parameter logic [7:0] LANE2_CODE = 8'h0D,
  parameter logic [7:0] LANE3_CODE = 8'h0E,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [7:0]                    keycode,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [1:0]                    ev_lane,
  output logic                          ev_press,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic [3:0]                    lane_held,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REL, S_PRS} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_kc_q;
  logic [7:0]       r_prev_kc;
  logic [1:0]       r_rel_lane;
  logic [1:0]       r_prs_lane;
  logic             r_prs_mapped;
  logic [3:0]       r_lane_held;
  logic             r_overflow;
  logic [2:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic [2:0]       w_kc_map;
  logic [2:0]       w_prev_map;
  logic             w_change;
  logic             w_push;
  logic [1:0]       w_push_lane;
  logic             w_push_press;
  logic             w_full;
  logic             w_pop;
  logic             w_accept;

  // Returns {mapped, lane}; lowest lane index wins on duplicate codes.
  function automatic logic [2:0] f_map(input logic [7:0] c);
    if (c == 8'h00)            return 3'b000;
    else if (c == LANE0_CODE)  return 3'b100;
    else if (c == LANE1_CODE)  return 3'b101;
    else if (c == LANE2_CODE)  return 3'b110;
    else if (c == LANE3_CODE)  return 3'b111;
    else                       return 3'b000;
  endfunction

  assign w_kc_map   = f_map(r_kc_q);
  assign w_prev_map = f_map(r_prev_kc);
  assign w_change   = (r_state == S_IDLE) && (r_kc_q != r_prev_kc);

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_change) begin
          if (w_prev_map[2])     w_next = S_REL;
          else if (w_kc_map[2])  w_next = S_PRS;
        end
      end
      S_REL:   w_next = r_prs_mapped ? S_PRS : S_IDLE;
      S_PRS:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_push       = 1'b0;
    w_push_lane  = 2'd0;
    w_push_press = 1'b0;
    case (r_state)
      S_REL: begin
        w_push      = 1'b1;
        w_push_lane = r_rel_lane;
      end
      S_PRS: begin
        w_push       = 1'b1;
        w_push_lane  = r_prs_lane;
        w_push_press = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_kc_q       <= 8'h00;
      r_prev_kc    <= 8'h00;
      r_rel_lane   <= 2'd0;
      r_prs_lane   <= 2'd0;
      r_prs_mapped <= 1'b0;
      r_lane_held  <= 4'b0000;
    end else begin
      r_kc_q <= keycode;
      if (w_change) begin
        r_prev_kc    <= r_kc_q;
        r_rel_lane   <= w_prev_map[1:0];
        r_prs_lane   <= w_kc_map[1:0];
        r_prs_mapped <= w_kc_map[2];
      end
      // Held level tracks every event, even ones the full FIFO drops.
      if (w_push) r_lane_held[w_push_lane] <= w_push_press;
    end
  end

  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = (r_count != '0) && ev_ready;
  assign w_accept = w_push && (!w_full || w_pop);

  always_ff @(posedge Clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= {w_push_lane, w_push_press};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_accept) r_overflow <= 1'b1;
    end
  end

  assign ev_valid  = (r_count != '0);
  assign ev_lane   = ev_valid ? r_mem[r_rd_ptr][2:1] : 2'd0;
  assign ev_press  = ev_valid ? r_mem[r_rd_ptr][0]   : 1'b0;
  assign ev_count  = r_count;
  assign lane_held = r_lane_held;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_keycode_lane_events.sv
// tb/tb_keycode_lane_events.sv - directed bench for keycode_lane_events
module tb_keycode_lane_events;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_lane;
  logic       ev_press;
  logic [3:0] ev_count;
  logic [3:0] lane_held;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic saw_valid;

  keycode_lane_events dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_lane   (ev_lane),
    .ev_press  (ev_press),
    .ev_count  (ev_count),
    .lane_held (lane_held),
    .overflow  (overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk_head(input string tag, input logic [1:0] lane, input logic press);
    chk({tag, "_valid"}, ev_valid, 1);
    chk({tag, "_lane"},  ev_lane,  lane);
    chk({tag, "_press"}, ev_press, press);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, ev_valid,  0);
    chk({tag, "_lane"},  ev_lane,   0);
    chk({tag, "_press"}, ev_press,  0);
    chk({tag, "_count"}, ev_count,  0);
    chk({tag, "_held"},  lane_held, 0);
    chk({tag, "_ovf"},   overflow,  0);
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; ev_ready = 1'b0;
    step(2);
    Reset = 1'b0;
    chk_all_zero("rst");

    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ev_valid) saw_valid = 1'b1;
    end
    chk("idle_no_valid", saw_valid, 0);
    chk("idle_held", lane_held, 0);

    // single press/release on lane 1, three cycles of latency
    ev_ready = 1'b1;
    keycode = 8'h09;
    step(2);
    chk("p1_early_valid", ev_valid, 0);
    step(1);
    chk_head("p1", 2'd1, 1'b1);
    chk("p1_held", lane_held, 4'b0010);
    step(1);
    chk("p1_popped", ev_valid, 0);
    chk("p1_count", ev_count, 0);
    keycode = 8'h00;
    step(3);
    chk_head("r1", 2'd1, 1'b0);
    chk("r1_held", lane_held, 4'b0000);
    step(1);

    // lane 0 -> lane 3 direct change: release then press on consecutive cycles
    keycode = 8'h07;
    step(4);
    chk("l0_held", lane_held, 4'b0001);
    keycode = 8'h0E;
    step(3);
    chk_head("x_rel", 2'd0, 1'b0);
    step(1);
    chk_head("x_prs", 2'd3, 1'b1);
    chk("x_held", lane_held, 4'b1000);
    step(1);
    chk("x_empty", ev_valid, 0);

    keycode = 8'h00;
    step(4);
    chk("k_held", lane_held, 4'b0000);

    // unmapped toggling produces nothing
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keycode = (i % 2 == 0) ? 8'h04 : 8'h00;
      step(2);
      if (ev_valid || ev_count != 0) saw_valid = 1'b1;
    end
    keycode = 8'h00;
    step(4);
    chk("unm_no_event", saw_valid, 0);
    chk("unm_count", ev_count, 0);

    // overflow: nine events into an eight-entry FIFO
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      keycode = (i % 2 == 0) ? 8'h0D : 8'h00;
      step(4);
    end
    chk("ovf_count", ev_count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_held", lane_held, 4'b0100);
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("ovf_d%0d", i), 2'd2, (i % 2 == 0));
      step(1);
    end
    chk("ovf_drained", ev_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // full FIFO with simultaneous pop and push
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      keycode = (i % 2 == 0) ? 8'h00 : 8'h0D;
      step(4);
    end
    chk("fp_full", ev_count, 8);
    keycode = 8'h00;
    step(2);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    chk("fp_count", ev_count, 8);
    chk("fp_held", lane_held, 4'b0000);
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("fp_d%0d", i), 2'd2, (i % 2 == 0));
      step(1);
    end
    chk("fp_drained", ev_count, 0);

    // reset while the FSM sits in REL
    keycode = 8'h0D;
    step(4);
    chk("mr_held_pre", lane_held, 4'b0100);
    keycode = 8'h00;
    step(2);
    Reset = 1'b1;
    keycode = 8'h0D;
    step(1);
    Reset = 1'b0;
    chk_all_zero("mr");
    step(1);
    chk("mr_no_event", ev_valid, 0);
    step(2);
    chk_head("mr_prs", 2'd2, 1'b1);
    chk("mr_held", lane_held, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
